// File: rtl/hs_upload_reader.sv
// rtl/hs_upload_reader.sv - serves hps_io NVRAM upload reads from the hiscore dump RAM
// The CPU is held paused for the whole upload so every byte read back is coherent.
module hs_upload_reader #(
  parameter int DUMPWIDTH  = 10,
  parameter int DUMPINDEX  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                 i_clk_sys,
  input  logic                 i_reset_n,
  input  logic                 i_ioctl_upload,
  input  logic [7:0]           i_ioctl_index,
  input  logic                 i_ioctl_rd,
  input  logic [24:0]          i_ioctl_addr,
  output logic [7:0]           o_ioctl_din,
  output logic                 o_ioctl_wait,
  output logic [DUMPWIDTH-1:0] o_ram_addr,
  output logic                 o_ram_rd,
  input  logic [7:0]           i_ram_q,
  input  logic                 i_cpu_paused,
  output logic                 o_pause_req,
  output logic                 o_upload_active,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE_WAIT, S_SERVE, S_FETCH, S_LATCH, S_RESUME
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_upload_d;
  logic                 r_pending;
  logic [24:0]          r_pend_addr;
  logic [1:0]           r_cnt;
  logic [7:0]           r_din;
  logic [DUMPWIDTH-1:0] r_ram_addr;

  logic        w_start;
  logic        w_fall;
  logic        w_req_valid;
  logic [24:0] w_req_addr;
  logic        w_req_in_range;
  logic        w_enter_fetch;
  logic        w_oor_reply;

  assign w_start    = !r_upload_d && i_ioctl_upload && (i_ioctl_index == 8'(DUMPINDEX));
  assign w_fall     = r_upload_d && !i_ioctl_upload;
  // A fresh strobe takes priority over an address parked while waiting for the pause.
  assign w_req_valid    = i_ioctl_rd || r_pending;
  assign w_req_addr     = i_ioctl_rd ? i_ioctl_addr : r_pend_addr;
  assign w_req_in_range = (w_req_addr[24:DUMPWIDTH] == '0);

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    o_ioctl_wait    = 1'b0;
    o_ram_rd        = 1'b0;
    o_pause_req     = 1'b0;
    o_upload_active = 1'b1;
    o_done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_upload_active = 1'b0;
        if (w_start) w_next = S_PAUSE_WAIT;
      end
      S_PAUSE_WAIT: begin
        o_ioctl_wait = 1'b1;
        o_pause_req  = 1'b1;
        if (w_fall)
          w_next = S_RESUME;
        else if (i_cpu_paused)
          w_next = (w_req_valid && w_req_in_range) ? S_FETCH : S_SERVE;
      end
      S_SERVE: begin
        o_pause_req = 1'b1;
        if (w_fall)
          w_next = S_RESUME;
        else if (i_ioctl_rd && w_req_in_range)
          w_next = S_FETCH;
      end
      S_FETCH: begin
        o_ioctl_wait = 1'b1;
        o_pause_req  = 1'b1;
        o_ram_rd     = (r_cnt == 2'd0);
        if (w_fall)
          w_next = S_RESUME;
        else if (r_cnt == 2'(RD_LATENCY - 1))
          w_next = S_LATCH;
      end
      S_LATCH: begin
        o_ioctl_wait = 1'b1;
        o_pause_req  = 1'b1;
        w_next       = w_fall ? S_RESUME : S_SERVE;
      end
      S_RESUME: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_fetch = (w_next == S_FETCH) && (r_state != S_FETCH);
  assign w_oor_reply   = ((r_state == S_SERVE) || (r_state == S_PAUSE_WAIT)) &&
                         (w_next == S_SERVE) && w_req_valid && !w_req_in_range;

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      r_upload_d  <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_addr <= '0;
      r_cnt       <= '0;
      r_din       <= '0;
      r_ram_addr  <= '0;
    end else begin
      r_upload_d <= i_ioctl_upload;

      if (w_next != S_PAUSE_WAIT) begin
        r_pending <= 1'b0;
      end else if (r_state == S_PAUSE_WAIT && i_ioctl_rd) begin
        r_pending   <= 1'b1;
        r_pend_addr <= i_ioctl_addr;
      end

      if (w_enter_fetch) begin
        r_cnt      <= '0;
        r_ram_addr <= w_req_addr[DUMPWIDTH-1:0];
      end else if (r_state == S_FETCH) begin
        r_cnt <= r_cnt + 2'd1;
      end

      // An abandoned fetch never reaches LATCH->SERVE, so the host byte stays put.
      if (r_state == S_LATCH && w_next == S_SERVE)
        r_din <= i_ram_q;
      else if (w_oor_reply)
        r_din <= 8'hFF;
    end
  end

  assign o_ioctl_din = r_din;
  assign o_ram_addr  = r_ram_addr;

endmodule

// File: tb/tb_hs_upload_reader.sv
// tb/tb_hs_upload_reader.sv - self-checking bench for hs_upload_reader
// Transaction-level expectations: a byte read returns RAM content or 0xFF, with fixed latency.
module tb_hs_upload_reader;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset_n, upload, rd, cpu_paused;
  logic [7:0]    index;
  logic [24:0]   addr;
  logic [7:0]    din;
  logic          wait_o;
  logic [DW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_q = 8'h00;
  logic          pause_req, active, done;

  logic [7:0] mem [0:(1<<DW)-1];

  int checks = 0;
  int errors = 0;
  int n_rd   = 0;
  int n_done = 0;

  logic [7:0]    m_din;
  logic [DW-1:0] m_raddr;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

  hs_upload_reader #(.DUMPWIDTH(DW), .DUMPINDEX(4), .RD_LATENCY(1)) dut (
    .i_clk_sys(clk), .i_reset_n(reset_n), .i_ioctl_upload(upload),
    .i_ioctl_index(index), .i_ioctl_rd(rd), .i_ioctl_addr(addr),
    .o_ioctl_din(din), .o_ioctl_wait(wait_o), .o_ram_addr(ram_addr),
    .o_ram_rd(ram_rd), .i_ram_q(ram_q), .i_cpu_paused(cpu_paused),
    .o_pause_req(pause_req), .o_upload_active(active), .o_done(done)
  );

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    int          nrd;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    n_rd   += int'(ram_rd);
    n_done += int'(done);
  endtask

  // Issue one strobe at a negedge and observe the five following cycles.
  task automatic check_read(input string tag, input logic [24:0] a,
                            input logic [7:0] exp_din, input int exp_nrd);
    logic [7:0] d1, d3;
    logic [4:0] wp;
    int         r0;
    bit         inr;
    inr = (a < 25'(1 << DW));
    r0  = n_rd;
    rd = 1'b1; addr = a;
    tick();
    rd = 1'b0; addr = 25'($urandom);
    wp[0] = wait_o; d1 = din;
    tick(); wp[1] = wait_o;
    tick(); wp[2] = wait_o; d3 = din;
    tick(); wp[3] = wait_o;
    tick(); wp[4] = wait_o;
    chk({tag, "_din1"}, 32'(d1), 32'(inr ? m_din : 8'hFF));
    chk({tag, "_din3"}, 32'(d3), 32'(exp_din));
    chk({tag, "_wait"}, 32'(wp), inr ? 32'b00011 : 32'b0);
    chk({tag, "_nrd"}, 32'(n_rd - r0), 32'(exp_nrd));
    if (inr) m_raddr = a[DW-1:0];
    chk({tag, "_raddr"}, 32'(ram_addr), 32'(m_raddr));
    m_din = exp_din;
  endtask

  task automatic open_upload();
    upload = 1'b1; index = 8'd4; cpu_paused = 1'b1;
    tick(); tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_w, acc_p, acc_a, r0, d0, k;
    logic [24:0] ra;
    logic [7:0]  held;

    for (int i = 0; i < (1 << DW); i++) mem[i] = 8'($urandom);
    mem[10'h012] = 8'hA5; mem[10'h3FF] = 8'h5A; mem[10'h000] = 8'h3C;
    mem[10'h200] = 8'h81; mem[10'h155] = 8'h11;
    vecs[0] = '{25'h012, 8'hA5, 1};
    vecs[1] = '{25'h400, 8'hFF, 0};
    vecs[2] = '{25'h3FF, 8'h5A, 1};
    vecs[3] = '{25'h000, 8'h3C, 1};
    vecs[4] = '{25'h1FFFFFF, 8'hFF, 0};
    vecs[5] = '{25'h200, 8'h81, 1};

    reset_n = 1'b0; upload = 1'b0; rd = 1'b0; addr = '0; index = '0; cpu_paused = 1'b0;
    tick(); tick(); tick();
    chk("rst_din", 32'(din), 0);
    chk("rst_wait", 32'(wait_o), 0);
    chk("rst_raddr", 32'(ram_addr), 0);
    chk("rst_ctl", 32'({ram_rd, pause_req, active, done}), 0);
    m_din = 8'h00; m_raddr = '0;
    reset_n = 1'b1;
    tick();

    // wrong index: nothing happens
    upload = 1'b1; index = 8'd3;
    acc_w = 0; acc_p = 0; acc_a = 0;
    repeat (6) begin
      tick();
      acc_w += int'(wait_o); acc_p += int'(pause_req); acc_a += int'(active);
    end
    chk("idx3_wait", 32'(acc_w), 0);
    chk("idx3_pause", 32'(acc_p), 0);
    chk("idx3_active", 32'(acc_a), 0);
    upload = 1'b0; tick(); tick();

    // start, pause granted after five cycles
    upload = 1'b1; index = 8'd4; cpu_paused = 1'b0;
    acc_w = 0; acc_p = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc_w += int'(wait_o); acc_p += int'(pause_req);
    end
    cpu_paused = 1'b1;
    chk("pw_wait_cycles", 32'(acc_w), 5);
    chk("pw_pause_cycles", 32'(acc_p), 5);
    tick();
    chk("serve_wait", 32'(wait_o), 0);
    chk("serve_pause", 32'(pause_req), 1);
    chk("serve_active", 32'(active), 1);

    for (int i = 0; i < 6; i++) check_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].din, vecs[i].nrd);

    // random reads; CPU pause may drop while serving and must be ignored
    for (int i = 0; i < 40; i++) begin
      cpu_paused = 1'($urandom);
      if ($urandom_range(7, 0) == 0) ra = 25'((1 << DW) + $urandom_range(40000, 0));
      else                           ra = 25'($urandom_range((1 << DW) - 1, 0));
      check_read($sformatf("rnd%0d", i), ra,
                 (ra < 25'(1 << DW)) ? mem[ra[DW-1:0]] : 8'hFF,
                 (ra < 25'(1 << DW)) ? 1 : 0);
      repeat ($urandom_range(2, 0)) tick();
    end
    chk("rnd_pause_held", 32'(pause_req), 1);

    // upload falls mid-fetch
    check_read("pre_abort", 25'h400, 8'hFF, 0);
    r0 = n_rd; d0 = n_done;
    rd = 1'b1; addr = 25'h012;
    tick();
    rd = 1'b0; upload = 1'b0;
    tick();
    chk("abort_done", 32'(done), 1);
    chk("abort_pause", 32'(pause_req), 0);
    tick(); tick();
    chk("abort_done_cnt", 32'(n_done - d0), 1);
    chk("abort_din", 32'(din), 32'h0FF);
    chk("abort_nrd", 32'(n_rd - r0), 1);
    chk("abort_idle", 32'({wait_o, active, pause_req}), 0);

    // reads parked during PAUSE_WAIT; the later one wins
    cpu_paused = 1'b0; upload = 1'b1; index = 8'd4;
    tick();
    rd = 1'b1; addr = 25'h155; tick();
    rd = 1'b1; addr = 25'h3FF; tick();
    rd = 1'b0; r0 = n_rd; tick();
    chk("pend_wait", 32'(wait_o), 1);
    cpu_paused = 1'b1;
    k = 0;
    while (k < 10) begin
      tick();
      if (!wait_o) break;
      k++;
    end
    chk("pend_latency", 32'(k), 2);
    chk("pend_din", 32'(din), 32'h05A);
    chk("pend_raddr", 32'(ram_addr), 32'h3FF);
    chk("pend_nrd", 32'(n_rd - r0), 1);
    upload = 1'b0; tick(); tick(); tick();

    // read and fall in the same cycle: the fall wins
    open_upload();
    held = din; r0 = n_rd; d0 = n_done;
    rd = 1'b1; addr = 25'h012; upload = 1'b0;
    tick(); rd = 1'b0; tick(); tick();
    chk("rdfall_nrd", 32'(n_rd - r0), 0);
    chk("rdfall_done", 32'(n_done - d0), 1);
    chk("rdfall_din", 32'(din), 32'(held));

    // reset mid-upload
    open_upload();
    rd = 1'b1; addr = 25'h200; tick();
    rd = 1'b0; reset_n = 1'b0; upload = 1'b0; d0 = n_done;
    tick();
    chk("mrst_ctl", 32'({pause_req, done, wait_o, active}), 0);
    chk("mrst_din", 32'(din), 0);
    chk("mrst_raddr", 32'(ram_addr), 0);
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("mrst_no_done", 32'(n_done - d0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
